ssb_audio_agc: RTL and testbench
================================

Name: ssb_audio_agc

Overview:
- Sideband combiner and audio AGC stage directly downstream of the Hilbert filter.
- Sums or differences the delayed I path and the Hilbert-transformed Q path to select USB or LSB.
- Applies a digital gain controlled by a peak/hang/decay AGC, or a manual gain, and saturates to audio width for the PWM/DAC output stage.

Parameters:
- DATA_WIDTH, 32, width of the signed I/Q inputs.
- OUT_WIDTH, 16, signed audio output width.
- GAIN_WIDTH, 16, unsigned gain width, fixed point with GAIN_FRAC fraction bits.
- GAIN_FRAC, 8, gain fraction bits (unity = 256).
- IN_SHIFT, 17, extra right shift mapping the 33-bit sum onto OUT_WIDTH.
- GAIN_INIT, 256, gain after reset.
- GAIN_MIN, 1, AGC lower clamp.
- GAIN_MAX, 65535, AGC upper clamp.
- TARGET, 16384, AGC magnitude threshold.
- ATTACK_SHIFT, 4, attack step divisor (shift).
- DECAY_SHIFT, 12, decay step divisor (shift).
- HANG_SAMPLES, 2048, samples gain is held after the last attack.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- data_ready  in  1  same sample strobe driving the Hilbert filter
- I_in  in  DATA_WIDTH  signed, Hilbert I_out
- Q_in  in  DATA_WIDTH  signed, Hilbert Q_out
- sideband  in  1  0 = USB (I+Q), 1 = LSB (I−Q)
- agc_en  in  1  1 = AGC, 0 = manual gain
- man_gain  in  GAIN_WIDTH  manual gain, Q(GAIN_WIDTH−GAIN_FRAC).GAIN_FRAC
- audio_out  out  OUT_WIDTH  signed audio sample
- audio_valid  out  1  one-clock pulse per new audio_out
- gain_out  out  GAIN_WIDTH  current gain register
- overload  out  1  audio_out of this sample was saturated; updated with audio_valid

Behaviour:
- Reset (async, rst_n low): audio_out=0, audio_valid=0, overload=0, gain_out=GAIN_INIT, hang counter=0, AGC state DECAY, all pipeline valid bits cleared. A sample in flight when reset asserts is discarded; no audio_valid follows for it.
- Capture: the Hilbert outputs change the clock after data_ready. The block registers data_ready once and captures I_in, Q_in and sideband on the following clock (S0).
- Pipeline, fully pipelined, one sample per clock max:
  - S0: capture.
  - S1: sum = I ± Q in DATA_WIDTH+1 bits, sign-extended, never overflows.
  - S2: product = sum × {0,gain}, signed, width DATA_WIDTH+GAIN_WIDTH+2. The gain used is the register value at S2.
  - S3: y = product >>> (GAIN_FRAC+IN_SHIFT), arithmetic floor. Saturate y to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1]. Drive audio_out, set overload = saturated, pulse audio_valid.
- Latency: audio_valid is high exactly 4 clocks after the data_ready cycle. Sample order is preserved.
- Gain, manual (agc_en=0): on each audio_valid, gain <= man_gain, hang counter <= 0, state DECAY.
- Gain, AGC (agc_en=1), evaluated on each audio_valid with m = |audio_out|, where −32768 maps to 32767:
  - m > TARGET → state ATTACK. gain <= max(GAIN_MIN, gain − (gain>>ATTACK_SHIFT) − 1). hang <= HANG_SAMPLES.
  - else hang ≠ 0 → state HANG. hang <= hang−1; gain held.
  - else → state DECAY. gain <= min(GAIN_MAX, gain + (gain>>DECAY_SHIFT) + 1).
- The new gain applies from the next sample entering S2; samples already past S2 keep the old gain.
- Switching agc_en 0→1: AGC starts from the current gain, with no jump.
- Gain arithmetic is computed one bit wider than GAIN_WIDTH before clamping; no wrap-around at GAIN_MIN or GAIN_MAX.
- A data_ready arriving on the same clock as an audio_valid is accepted normally.

Decomposition:
- Package gowin_trx_pkg holds:
  - AUDIO_WIDTH, GAIN_FRAC, UNITY_GAIN constants;
  - sideband encoding SB_USB=0, SB_LSB=1;
  - AGC state encoding ST_DECAY, ST_ATTACK, ST_HANG.
- One sub-module, agc_gain_ctrl, holds the state register, hang counter, gain register, step and clamp logic. The parent holds the datapath pipeline and saturation.

Test Plan:
- Reset mid-stream: rst_n low while a sample is at S1 → audio_out=0, audio_valid never pulses for that sample, gain_out=256.
- USB/LSB manual: agc_en=0, man_gain=256, I=2^20, Q=2^19.
  - sideband=0 → audio_out=12, valid exactly 4 clocks after data_ready.
  - sideband=1 → audio_out=4, overload=0.
- Saturation:
  - I=Q=0x7FFFFFFF, gain 256 → 32767, overload=0; gain 512 → 32767, overload=1.
  - I=Q=0x80000000, gain 256 → −32768, overload=0; gain 512 → −32768, overload=1.
- AGC attack: agc_en=1, start gain 256, full-scale input → gain_out sequence 239, 224, 209 …; hang reloaded each sample.
- Hang/decay (HANG_SAMPLES=4): after attack ends at gain 224, zero input → gain holds 224 for 4 samples, then 225, 226 …; with GAIN_MAX=230 it stops at 230.
- Throughput: data_ready every clock for 20 clocks with a ramp on I_in → 20 consecutive audio_valid pulses, values in input order, first 4 clocks after the first data_ready.

Source files
------------

// File: rtl/gowin_trx_pkg.sv
// Shared constants and encodings for the transceiver audio path.
// Used by the sideband combiner / AGC stage and its gain controller.
package gowin_trx_pkg;

   localparam int   AUDIO_WIDTH = 32'd16;
   localparam int   GAIN_FRAC   = 32'd8;
   localparam int   UNITY_GAIN  = 32'd256;

   localparam logic SB_USB      = 1'b0;
   localparam logic SB_LSB      = 1'b1;

   typedef enum logic [1:0] {
      ST_DECAY  = 2'd0,
      ST_ATTACK = 2'd1,
      ST_HANG   = 2'd2
   } agc_state_e;

endpackage

// File: rtl/ssb_audio_agc_gain_ctrl.sv
// Peak/hang/decay AGC gain controller with manual-gain bypass.
// Evaluates one finished audio sample per sample_valid and updates the gain register.
module agc_gain_ctrl
   import gowin_trx_pkg::*;
#(
   parameter int OUT_WIDTH    = AUDIO_WIDTH,
   parameter int GAIN_WIDTH   = 32'd16,
   parameter int GAIN_INIT    = UNITY_GAIN,
   parameter int GAIN_MIN     = 32'd1,
   parameter int GAIN_MAX     = 32'd65535,
   parameter int TARGET       = 32'd16384,
   parameter int ATTACK_SHIFT = 32'd4,
   parameter int DECAY_SHIFT  = 32'd12,
   parameter int HANG_SAMPLES = 32'd2048
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sample_valid,
   input  logic [OUT_WIDTH-1:0]  sample,
   input  logic                  agc_en,
   input  logic [GAIN_WIDTH-1:0] man_gain,
   output logic [GAIN_WIDTH-1:0] gain
);

   localparam int HANG_W = $clog2(HANG_SAMPLES + 32'd1) + 32'd1;

   localparam logic [OUT_WIDTH-1:0]  OUT_MIN_V = {1'b1, {(OUT_WIDTH-1){1'b0}}};
   localparam logic [OUT_WIDTH-1:0]  OUT_MAX_V = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   localparam logic [OUT_WIDTH-1:0]  ONE_O     = {{(OUT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [OUT_WIDTH-1:0]  TARGET_V  = TARGET[OUT_WIDTH-1:0];
   localparam logic [GAIN_WIDTH-1:0] GINIT_V   = GAIN_INIT[GAIN_WIDTH-1:0];
   localparam logic [GAIN_WIDTH-1:0] GMIN_V    = GAIN_MIN[GAIN_WIDTH-1:0];
   localparam logic [GAIN_WIDTH-1:0] GMAX_V    = GAIN_MAX[GAIN_WIDTH-1:0];
   localparam logic [GAIN_WIDTH:0]   ONE_G     = {{GAIN_WIDTH{1'b0}}, 1'b1};
   localparam logic [HANG_W-1:0]     HANG_V    = HANG_SAMPLES[HANG_W-1:0];
   localparam logic [HANG_W-1:0]     ONE_H     = {{(HANG_W-1){1'b0}}, 1'b1};

   agc_state_e            state_r, state_n;
   logic [GAIN_WIDTH-1:0] gain_r, gain_n;
   logic [HANG_W-1:0]     hang_r, hang_n;
   logic [OUT_WIDTH-1:0]  mag_s;
   logic [GAIN_WIDTH:0]   att_s, dec_s;
   logic [GAIN_WIDTH-1:0] att_g_s, dec_g_s;

   // Magnitude of the output sample; the most negative code folds onto full scale.
   always_comb begin
      mag_s = sample;
      if (sample == OUT_MIN_V) begin
         mag_s = OUT_MAX_V;
      end else if (sample[OUT_WIDTH-1]) begin
         mag_s = ~sample + ONE_O;
      end else begin
         mag_s = sample;
      end
   end

   // Attack/decay steps one bit wider than the gain so the clamps never see a wrapped value.
   always_comb begin
      att_s   = {1'b0, gain_r} - {1'b0, gain_r >> ATTACK_SHIFT} - ONE_G;
      dec_s   = {1'b0, gain_r} + {1'b0, gain_r >> DECAY_SHIFT} + ONE_G;
      att_g_s = att_s[GAIN_WIDTH-1:0];
      dec_g_s = dec_s[GAIN_WIDTH-1:0];
      if (att_s[GAIN_WIDTH] || (att_s < {1'b0, GMIN_V})) begin
         att_g_s = GMIN_V;
      end else begin
         att_g_s = att_s[GAIN_WIDTH-1:0];
      end
      if (dec_s > {1'b0, GMAX_V}) begin
         dec_g_s = GMAX_V;
      end else begin
         dec_g_s = dec_s[GAIN_WIDTH-1:0];
      end
   end

   // Next state, gain and hang count, evaluated once per finished sample.
   always_comb begin
      state_n = state_r;
      gain_n  = gain_r;
      hang_n  = hang_r;
      if (sample_valid) begin
         if (!agc_en) begin
            state_n = ST_DECAY;
            gain_n  = man_gain;
            hang_n  = {HANG_W{1'b0}};
         end else if (mag_s > TARGET_V) begin
            state_n = ST_ATTACK;
            gain_n  = att_g_s;
            hang_n  = HANG_V;
         end else if (hang_r != {HANG_W{1'b0}}) begin
            state_n = ST_HANG;
            hang_n  = hang_r - ONE_H;
         end else begin
            state_n = ST_DECAY;
            gain_n  = dec_g_s;
         end
      end else begin
         state_n = state_r;
      end
   end

   // State, gain and hang registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_DECAY;
         gain_r  <= GINIT_V;
         hang_r  <= {HANG_W{1'b0}};
      end else begin
         state_r <= state_n;
         gain_r  <= gain_n;
         hang_r  <= hang_n;
      end
   end

   assign gain = gain_r;

endmodule

// File: rtl/ssb_audio_agc.sv
// Sideband combiner (I +/- Q) with AGC or manual gain and saturation to audio width.
// Output appears four clocks after the data_ready strobe; one sample per clock sustained.
module ssb_audio_agc
   import gowin_trx_pkg::*;
#(
   parameter int DATA_WIDTH   = 32'd32,
   parameter int OUT_WIDTH    = AUDIO_WIDTH,
   parameter int GAIN_WIDTH   = 32'd16,
   parameter int GAIN_FRAC    = gowin_trx_pkg::GAIN_FRAC,
   parameter int IN_SHIFT     = 32'd17,
   parameter int GAIN_INIT    = UNITY_GAIN,
   parameter int GAIN_MIN     = 32'd1,
   parameter int GAIN_MAX     = 32'd65535,
   parameter int TARGET       = 32'd16384,
   parameter int ATTACK_SHIFT = 32'd4,
   parameter int DECAY_SHIFT  = 32'd12,
   parameter int HANG_SAMPLES = 32'd2048
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         data_ready,
   input  logic signed [DATA_WIDTH-1:0] I_in,
   input  logic signed [DATA_WIDTH-1:0] Q_in,
   input  logic                         sideband,
   input  logic                         agc_en,
   input  logic        [GAIN_WIDTH-1:0] man_gain,
   output logic signed [OUT_WIDTH-1:0]  audio_out,
   output logic                         audio_valid,
   output logic        [GAIN_WIDTH-1:0] gain_out,
   output logic                         overload
);

   localparam int SUM_W  = DATA_WIDTH + 32'd1;
   localparam int PROD_W = DATA_WIDTH + GAIN_WIDTH + 32'd2;
   localparam int SHIFT  = GAIN_FRAC + IN_SHIFT;

   localparam logic signed [PROD_W-1:0] OUT_MAX_P = {{(PROD_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [PROD_W-1:0] OUT_MIN_P = {{(PROD_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
   localparam logic [OUT_WIDTH-1:0]     OUT_MAX_O = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   localparam logic [OUT_WIDTH-1:0]     OUT_MIN_O = {1'b1, {(OUT_WIDTH-1){1'b0}}};

   logic                     dr_r, v1_r, v2_r, valid_r, ovf_r;
   logic signed [SUM_W-1:0]  i_ext_s, q_ext_s, sum_s, sum_r;
   logic signed [PROD_W-1:0] prod_a_s, prod_b_s, prod_s, prod_r, y_s;
   logic [OUT_WIDTH-1:0]     sat_s, audio_r;
   logic                     ovf_s;
   logic [GAIN_WIDTH-1:0]    gain_s;

   // Sideband selection on the live Hilbert outputs; the extra bit keeps I +/- Q exact.
   always_comb begin
      i_ext_s = {I_in[DATA_WIDTH-1], I_in};
      q_ext_s = {Q_in[DATA_WIDTH-1], Q_in};
      if (sideband == SB_USB) begin
         sum_s = i_ext_s + q_ext_s;
      end else begin
         sum_s = i_ext_s - q_ext_s;
      end
   end

   // Gain multiply: the gain is treated as a non-negative signed operand.
   always_comb begin
      prod_a_s = {{(PROD_W-SUM_W){sum_r[SUM_W-1]}}, sum_r};
      prod_b_s = {{(PROD_W-GAIN_WIDTH){1'b0}}, gain_s};
      prod_s   = prod_a_s * prod_b_s;
   end

   // Scale back to audio width with floor rounding and clip to the signed output range.
   always_comb begin
      y_s   = prod_r >>> SHIFT;
      sat_s = y_s[OUT_WIDTH-1:0];
      ovf_s = 1'b0;
      if (y_s > OUT_MAX_P) begin
         sat_s = OUT_MAX_O;
         ovf_s = 1'b1;
      end else if (y_s < OUT_MIN_P) begin
         sat_s = OUT_MIN_O;
         ovf_s = 1'b1;
      end else begin
         sat_s = y_s[OUT_WIDTH-1:0];
         ovf_s = 1'b0;
      end
   end

   // Pipeline: strobe delay, capture+sum, product, saturated output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dr_r    <= 1'b0;
         v1_r    <= 1'b0;
         v2_r    <= 1'b0;
         valid_r <= 1'b0;
         ovf_r   <= 1'b0;
         sum_r   <= {SUM_W{1'b0}};
         prod_r  <= {PROD_W{1'b0}};
         audio_r <= {OUT_WIDTH{1'b0}};
      end else begin
         dr_r    <= data_ready;
         v1_r    <= dr_r;
         v2_r    <= v1_r;
         valid_r <= v2_r;
         if (dr_r) begin
            sum_r <= sum_s;
         end
         if (v1_r) begin
            prod_r <= prod_s;
         end
         if (v2_r) begin
            audio_r <= sat_s;
            ovf_r   <= ovf_s;
         end
      end
   end

   agc_gain_ctrl #(
      .OUT_WIDTH    (OUT_WIDTH),
      .GAIN_WIDTH   (GAIN_WIDTH),
      .GAIN_INIT    (GAIN_INIT),
      .GAIN_MIN     (GAIN_MIN),
      .GAIN_MAX     (GAIN_MAX),
      .TARGET       (TARGET),
      .ATTACK_SHIFT (ATTACK_SHIFT),
      .DECAY_SHIFT  (DECAY_SHIFT),
      .HANG_SAMPLES (HANG_SAMPLES)
   ) u_gain_ctrl (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_valid (valid_r),
      .sample       (audio_r),
      .agc_en       (agc_en),
      .man_gain     (man_gain),
      .gain         (gain_s)
   );

   assign audio_out   = audio_r;
   assign audio_valid = valid_r;
   assign overload    = ovf_r;
   assign gain_out    = gain_s;

endmodule

// File: tb/tb_ssb_audio_agc.sv
// Self-checking bench for ssb_audio_agc: directed cases plus random samples against a behavioural model.
module tb_ssb_audio_agc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        data_ready;
   logic [31:0] I_in, Q_in;
   logic        sideband, agc_en;
   logic [15:0] man_gain;
   logic [15:0] audio_out;
   logic        audio_valid;
   logic [15:0] gain_out;
   logic        overload;

   int n_pass  = 0;
   int n_total = 0;
   int mg      = 256;
   int mh      = 0;
   logic [15:0] r_out;
   logic        r_ovf;

   always #5 clk = ~clk;

   ssb_audio_agc #(
      .HANG_SAMPLES (4),
      .GAIN_MAX     (230)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .data_ready  (data_ready),
      .I_in        (I_in),
      .Q_in        (Q_in),
      .sideband    (sideband),
      .agc_en      (agc_en),
      .man_gain    (man_gain),
      .audio_out   (audio_out),
      .audio_valid (audio_valid),
      .gain_out    (gain_out),
      .overload    (overload)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // One isolated sample: predict output from the model, run it, check latency/value/gain.
   task automatic sample_chk(input string tag, input logic [31:0] i_v, input logic [31:0] q_v, input logic sb);
      longint s, p, y;
      logic [15:0] e_out;
      logic e_ovf;
      int lat, m, o;
      bit seen;
      s = longint'($signed(i_v));
      if (sb) s = s - longint'($signed(q_v));
      else    s = s + longint'($signed(q_v));
      p = s * longint'(mg);
      y = p >>> 25;
      if (y > 32767) begin
         e_out = 16'h7FFF; e_ovf = 1'b1;
      end else if (y < -32768) begin
         e_out = 16'h8000; e_ovf = 1'b1;
      end else begin
         e_out = y[15:0]; e_ovf = 1'b0;
      end
      @(posedge clk); #1;
      data_ready = 1'b1;
      @(posedge clk); #1;
      data_ready = 1'b0;
      I_in = i_v; Q_in = q_v; sideband = sb;
      lat = 1; seen = 1'b0;
      while (!seen && lat < 12) begin
         @(posedge clk); #1;
         lat++;
         seen = audio_valid;
      end
      if (!seen) lat = -1;
      r_out = audio_out;
      r_ovf = overload;
      chk({tag, "_lat"}, lat, 4);
      chk({tag, "_out"}, audio_out, e_out);
      chk({tag, "_ovf"}, overload, e_ovf);
      o = int'($signed(e_out));
      if (!agc_en) begin
         mg = man_gain; mh = 0;
      end else begin
         m = (o == -32768) ? 32767 : ((o < 0) ? -o : o);
         if (m > 16384) begin
            mg = mg - (mg / 16) - 1;
            if (mg < 1) mg = 1;
            mh = 4;
         end else if (mh != 0) begin
            mh = mh - 1;
         end else begin
            mg = mg + (mg / 4096) + 1;
            if (mg > 230) mg = 230;
         end
      end
      @(posedge clk); #1;
      chk({tag, "_pulse"}, audio_valid, 1'b0);
      chk({tag, "_gain"}, gain_out, mg);
   endtask

   initial begin
      logic [31:0] iv, qv;
      int seen_v;
      rst_n = 1'b0; data_ready = 1'b0; I_in = 32'd0; Q_in = 32'd0;
      sideband = 1'b0; agc_en = 1'b0; man_gain = 16'd256;
      #12;
      chk("rst_out", audio_out, 16'd0);
      chk("rst_valid", audio_valid, 1'b0);
      chk("rst_ovf", overload, 1'b0);
      chk("rst_gain", gain_out, 16'd256);
      #10 rst_n = 1'b1;

      // Manual gain, both sidebands.
      sample_chk("usb", 32'h0010_0000, 32'h0008_0000, 1'b0);
      chk("usb_12", r_out, 16'd12);
      sample_chk("lsb", 32'h0010_0000, 32'h0008_0000, 1'b1);
      chk("lsb_4", r_out, 16'd4);
      chk("lsb_ovf0", r_ovf, 1'b0);

      // Saturation at both rails, with and without clipping.
      sample_chk("pos256", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
      chk("pos256_v", {r_out, r_ovf}, {16'h7FFF, 1'b0});
      man_gain = 16'd512;
      sample_chk("load512", 32'd0, 32'd0, 1'b0);
      sample_chk("pos512", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
      chk("pos512_v", {r_out, r_ovf}, {16'h7FFF, 1'b1});
      sample_chk("neg512", 32'h8000_0000, 32'h8000_0000, 1'b0);
      chk("neg512_v", {r_out, r_ovf}, {16'h8000, 1'b1});
      man_gain = 16'd256;
      sample_chk("load256", 32'd0, 32'd0, 1'b0);
      sample_chk("neg256", 32'h8000_0000, 32'h8000_0000, 1'b0);
      chk("neg256_v", {r_out, r_ovf}, {16'h8000, 1'b0});
      man_gain = 16'd512;
      sample_chk("load512b", 32'd0, 32'd0, 1'b0);

      // Reset while a sample sits in the pipeline: it must vanish.
      @(posedge clk); #1;
      data_ready = 1'b1;
      @(posedge clk); #1;
      data_ready = 1'b0; I_in = 32'h7FFF_FFFF; Q_in = 32'h7FFF_FFFF;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out", audio_out, 16'd0);
      chk("mid_rst_gain", gain_out, 16'd256);
      mg = 256; mh = 0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      seen_v = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (audio_valid) seen_v++;
      end
      chk("mid_rst_novalid", seen_v, 0);

      // AGC attack from unity.
      man_gain = 16'd256; agc_en = 1'b1;
      sample_chk("att1", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
      chk("att1_g", gain_out, 16'd239);
      sample_chk("att2", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
      chk("att2_g", gain_out, 16'd224);
      sample_chk("att3", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
      chk("att3_g", gain_out, 16'd209);

      // Hang then decay up to the ceiling, starting from an attack that ends at 224.
      agc_en = 1'b0; man_gain = 16'd239;
      sample_chk("load239", 32'd0, 32'd0, 1'b0);
      agc_en = 1'b1;
      sample_chk("att239", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
      chk("att239_g", gain_out, 16'd224);
      for (int k = 1; k <= 12; k++) begin
         sample_chk("hangdec", 32'd0, 32'd0, 1'b0);
         if (k == 4)  chk("hang4_g", gain_out, 16'd224);
         if (k == 5)  chk("dec1_g", gain_out, 16'd225);
         if (k == 12) chk("decmax_g", gain_out, 16'd230);
      end

      // Random samples, random mode and gain.
      for (int k = 0; k < 16; k++) begin
         agc_en   = 1'($urandom_range(0, 1));
         man_gain = 16'($urandom_range(0, 700));
         iv = $signed($urandom) >>> $urandom_range(0, 20);
         qv = $signed($urandom) >>> $urandom_range(0, 20);
         sample_chk("rand", iv, qv, 1'($urandom_range(0, 1)));
      end

      // Back-to-back samples: one strobe per clock for 20 clocks with a ramp on I.
      agc_en = 1'b0; man_gain = 16'd256;
      sample_chk("prime", 32'd0, 32'd0, 1'b0);
      for (int c = 0; c <= 30; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
            chk("thr_valid", audio_valid, (c >= 4 && c <= 23) ? 1'b1 : 1'b0);
            if (c >= 4 && c <= 23) chk("thr_out", audio_out, 16'(8 * (c - 3)));
         end
         data_ready = (c < 20) ? 1'b1 : 1'b0;
         I_in = (c >= 1 && c <= 20) ? (32'(c) << 20) : 32'd0;
         Q_in = 32'd0; sideband = 1'b0;
      end
      chk("thr_gain", gain_out, 16'd256);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
